// File: rtl/dds_freq_sequencer_if.sv
// rtl/dds_freq_sequencer_if.sv - command and NCO word bundle for dds_freq_sequencer (optional trim: DDS_FREQ_TRIM_EN)
interface dds_freq_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_mode;
  logic [1:0]  cmd_sel;
  logic [15:0] cmd_phase;
  logic [15:0] cmd_dwell;
  logic        stop;
  logic [31:0] PhaseInc;
  logic [31:0] FreqMod;
  logic [15:0] PhaseMod;
  logic [1:0]  freq_idx;
  logic        dds_upd;
  logic        acq_en;
  logic        busy;
`ifdef DDS_FREQ_TRIM_EN
  logic signed [15:0] trim;

  modport master (
    output cmd_valid, cmd_mode, cmd_sel, cmd_phase, cmd_dwell, stop, trim,
    input  cmd_ready, PhaseInc, FreqMod, PhaseMod, freq_idx, dds_upd, acq_en, busy
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_sel, cmd_phase, cmd_dwell, stop, trim,
    output cmd_ready, PhaseInc, FreqMod, PhaseMod, freq_idx, dds_upd, acq_en, busy
  );
`else
  modport master (
    output cmd_valid, cmd_mode, cmd_sel, cmd_phase, cmd_dwell, stop,
    input  cmd_ready, PhaseInc, FreqMod, PhaseMod, freq_idx, dds_upd, acq_en, busy
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_sel, cmd_phase, cmd_dwell, stop,
    output cmd_ready, PhaseInc, FreqMod, PhaseMod, freq_idx, dds_upd, acq_en, busy
  );
`endif
endinterface

// File: rtl/dds_freq_sequencer.sv
// rtl/dds_freq_sequencer.sv - DDS tuning-word sequencer with settle/dwell acquisition gating (optional trim: DDS_FREQ_TRIM_EN)
module dds_freq_sequencer #(
  parameter logic [31:0] F100K      = 32'd42949673,
  parameter logic [31:0] F200K      = 32'd85899346,
  parameter logic [31:0] F500K      = 32'd214748365,
  parameter logic [31:0] F1M        = 32'd429496730,
  parameter int          SETTLE_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  dds_freq_sequencer_if.slave sif
);

  // Settle counter runs SETTLE_CYC-1 down to 0, so SETTLE_CYC cycles in SETTLE.
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_DWELL} state_t;

  state_t      r_state;
  logic        r_mode;
  logic [15:0] r_dwell;
  logic [15:0] r_dwell_cnt;
  logic [SW-1:0] r_settle_cnt;
  logic [31:0] r_phase_inc;
  logic [15:0] r_phase_mod;
  logic [1:0]  r_freq_idx;
  logic        r_dds_upd;
  logic        r_acq_en;
  logic        w_accept;
  logic [1:0]  w_next_idx;

  function automatic logic [31:0] f_word(input logic [1:0] idx);
    case (idx)
      2'd0:    f_word = F100K;
      2'd1:    f_word = F200K;
      2'd2:    f_word = F500K;
      default: f_word = F1M;
    endcase
  endfunction

  assign w_accept   = sif.cmd_valid && (r_state == S_IDLE);
  assign w_next_idx = r_freq_idx + 2'd1;

`ifdef DDS_FREQ_TRIM_EN
  logic [31:0] r_freq_mod;
  logic [31:0] w_trim_ext;

  assign w_trim_ext = {{16{sif.trim[15]}}, sif.trim};

  // Trim is captured on every edge entering LOAD, alongside the new tuning word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq_mod <= 32'd0;
    end else if (w_accept ||
                 (r_state == S_DWELL && !sif.stop && r_dwell_cnt == 16'd0 && r_mode)) begin
      r_freq_mod <= w_trim_ext;
    end
  end

  assign sif.FreqMod = r_freq_mod;
`else
  assign sif.FreqMod = 32'd0;
`endif

  // Main sequencer: IDLE -> LOAD -> SETTLE -> DWELL, stop returns to IDLE keeping the words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_dwell      <= 16'd0;
      r_dwell_cnt  <= 16'd0;
      r_settle_cnt <= '0;
      r_phase_inc  <= F200K;
      r_phase_mod  <= 16'd0;
      r_freq_idx   <= 2'd1;
      r_dds_upd    <= 1'b0;
      r_acq_en     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_dds_upd <= 1'b0;
          r_acq_en  <= 1'b0;
          if (w_accept) begin
            r_mode      <= sif.cmd_mode;
            r_dwell     <= (sif.cmd_dwell == 16'd0) ? 16'd1 : sif.cmd_dwell;
            r_phase_inc <= f_word(sif.cmd_sel);
            r_phase_mod <= sif.cmd_phase;
            r_freq_idx  <= sif.cmd_sel;
            r_dds_upd   <= 1'b1;
            r_state     <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_dds_upd <= 1'b0;
          r_acq_en  <= 1'b0;
          if (sif.stop) begin
            r_state <= S_IDLE;
          end else begin
            r_settle_cnt <= SETTLE_LAST;
            r_state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (sif.stop) begin
            r_settle_cnt <= '0;
            r_state      <= S_IDLE;
          end else if (r_settle_cnt == '0) begin
            r_acq_en    <= 1'b1;
            r_dwell_cnt <= r_dwell - 16'd1;
            r_state     <= S_DWELL;
          end else begin
            r_settle_cnt <= r_settle_cnt - 1'b1;
          end
        end

        S_DWELL: begin
          if (sif.stop) begin
            r_acq_en    <= 1'b0;
            r_dwell_cnt <= 16'd0;
            r_state     <= S_IDLE;
          end else if (r_dwell_cnt == 16'd0) begin
            r_acq_en <= 1'b0;
            if (r_mode) begin
              r_freq_idx  <= w_next_idx;
              r_phase_inc <= f_word(w_next_idx);
              r_dds_upd   <= 1'b1;
              r_state     <= S_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt - 16'd1;
          end
        end

        default: begin
          r_dds_upd <= 1'b0;
          r_acq_en  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign sif.cmd_ready = (r_state == S_IDLE);
  assign sif.busy      = (r_state != S_IDLE);
  assign sif.PhaseInc  = r_phase_inc;
  assign sif.PhaseMod  = r_phase_mod;
  assign sif.freq_idx  = r_freq_idx;
  assign sif.dds_upd   = r_dds_upd;
  assign sif.acq_en    = r_acq_en;

endmodule

// File: tb/tb_dds_freq_sequencer.sv
// tb/tb_dds_freq_sequencer.sv - directed scoreboard bench for dds_freq_sequencer
module tb_dds_freq_sequencer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [15:0] tb_trim;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  idx;
    logic [15:0] phase;
    logic [31:0] fmod;
  } exp_t;

  exp_t sb_q[$];

  dds_freq_sequencer_if sif ();

  dds_freq_sequencer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] tb_word(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'd42949673;
      2'd1:    return 32'd85899346;
      2'd2:    return 32'd214748365;
      default: return 32'd429496730;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] idx, input logic [15:0] phase);
    exp_t e;
    e.word  = tb_word(idx);
    e.idx   = idx;
    e.phase = phase;
`ifdef DDS_FREQ_TRIM_EN
    e.fmod  = {{16{tb_trim[15]}}, tb_trim};
`else
    e.fmod  = 32'd0;
`endif
    sb_q.push_back(e);
  endtask

  // Every dds_upd strobe must match the next expected word change.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sif.dds_upd === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("upd_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("upd_phaseinc", sif.PhaseInc, e.word);
        chk("upd_freq_idx", 32'(sif.freq_idx), 32'(e.idx));
        chk("upd_phasemod", 32'(sif.PhaseMod), 32'(e.phase));
        chk("upd_freqmod", sif.FreqMod, e.fmod);
        chk("upd_acq_low", 32'(sif.acq_en), 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Called at a negedge in IDLE (or waiting for IDLE); returns just after the accept edge.
  task automatic issue(input logic mode, input logic [1:0] sel,
                       input logic [15:0] phase, input logic [15:0] dwell);
    int n;
    n = 0;
    sif.cmd_valid = 1'b1;
    sif.cmd_mode  = mode;
    sif.cmd_sel   = sel;
    sif.cmd_phase = phase;
    sif.cmd_dwell = dwell;
    while (sif.cmd_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(sif.cmd_ready), 32'd1);
    push(sel, phase);
    @(posedge clk);
    #1;
    sif.cmd_valid = 1'b0;
  endtask

  // Counts low acq_en samples from the current negedge; stops at the first high sample.
  task automatic count_low(output int n);
    n = 0;
    while (sif.acq_en !== 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (sif.acq_en === 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lo;
    int hi;
    int seen_acq;
    checks = 0;
    errors = 0;
    tb_trim = 16'd0;
    rst_n = 1'b0;
    sif.cmd_valid = 1'b0;
    sif.cmd_mode  = 1'b0;
    sif.cmd_sel   = 2'd0;
    sif.cmd_phase = 16'd0;
    sif.cmd_dwell = 16'd0;
    sif.stop      = 1'b0;
`ifdef DDS_FREQ_TRIM_EN
    sif.trim      = 16'd0;
`endif

    // 1: reset values
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_phaseinc", sif.PhaseInc, 32'd85899346);
    chk("rst_freqmod", sif.FreqMod, 32'd0);
    chk("rst_phasemod", 32'(sif.PhaseMod), 32'd0);
    chk("rst_freq_idx", 32'(sif.freq_idx), 32'd1);
    chk("rst_acq_en", 32'(sif.acq_en), 32'd0);
    chk("rst_dds_upd", 32'(sif.dds_upd), 32'd0);
    chk("rst_busy", 32'(sif.busy), 32'd0);
    chk("rst_cmd_ready", 32'(sif.cmd_ready), 32'd1);

    // 2: fixed mode, sel=3, dwell=10
    tb_trim = 16'd5;
`ifdef DDS_FREQ_TRIM_EN
    sif.trim = tb_trim;
`endif
    issue(1'b0, 2'd3, 16'h4000, 16'd10);
    @(negedge clk);
    count_low(lo);
    chk("fix_low_cycles", 32'(lo), 32'd65);
    count_high(hi);
    chk("fix_high_cycles", 32'(hi), 32'd10);
    chk("fix_busy", 32'(sif.busy), 32'd0);
    chk("fix_cmd_ready", 32'(sif.cmd_ready), 32'd1);
    chk("fix_phaseinc_kept", sif.PhaseInc, 32'd429496730);
    chk("fix_phasemod_kept", 32'(sif.PhaseMod), 32'h4000);
    chk("fix_idx_kept", 32'(sif.freq_idx), 32'd3);

    // 3: scan from sel=2, dwell=5; stop during the fifth window
    tb_trim = 16'hFFFD;
`ifdef DDS_FREQ_TRIM_EN
    sif.trim = tb_trim;
`endif
    issue(1'b1, 2'd2, 16'h0123, 16'd5);
    push(2'd3, 16'h0123);
    push(2'd0, 16'h0123);
    push(2'd1, 16'h0123);
    push(2'd2, 16'h0123);
    @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      count_low(lo);
      chk("scan_low_cycles", 32'(lo), 32'd65);
      count_high(hi);
      chk("scan_high_cycles", 32'(hi), 32'd5);
    end
    count_low(lo);
    chk("scan5_low_cycles", 32'(lo), 32'd65);
    @(negedge clk);
    sif.stop = 1'b1;
    @(negedge clk);
    sif.stop = 1'b0;
    chk("scan_stop_busy", 32'(sif.busy), 32'd0);
    chk("scan_stop_acq", 32'(sif.acq_en), 32'd0);
    chk("scan_stop_phaseinc", sif.PhaseInc, 32'd214748365);
    chk("scan_stop_idx", 32'(sif.freq_idx), 32'd2);

    // 4: stop in SETTLE cycle 20
    issue(1'b0, 2'd0, 16'h1234, 16'd8);
    @(negedge clk);
    repeat (20) @(negedge clk);
    sif.stop = 1'b1;
    @(negedge clk);
    sif.stop = 1'b0;
    chk("settle_stop_busy", 32'(sif.busy), 32'd0);
    seen_acq = 0;
    repeat (80) begin
      if (sif.acq_en === 1'b1) seen_acq = 1;
      @(negedge clk);
    end
    chk("settle_stop_no_acq", 32'(seen_acq), 32'd0);
    chk("settle_stop_phaseinc", sif.PhaseInc, 32'd42949673);

    // scan end-of-dwell coinciding with stop: no advance, no strobe
    issue(1'b1, 2'd0, 16'h0055, 16'd3);
    @(negedge clk);
    count_low(lo);
    repeat (2) @(negedge clk);
    sif.stop = 1'b1;
    @(negedge clk);
    sif.stop = 1'b0;
    chk("endstop_busy", 32'(sif.busy), 32'd0);
    chk("endstop_idx", 32'(sif.freq_idx), 32'd0);
    chk("endstop_phaseinc", sif.PhaseInc, 32'd42949673);
    chk("endstop_dds_upd", 32'(sif.dds_upd), 32'd0);

    // 5: command held during DWELL; dwell=0 gives a single acq cycle
    issue(1'b0, 2'd1, 16'h0001, 16'd4);
    @(negedge clk);
    count_low(lo);
    sif.cmd_valid = 1'b1;
    sif.cmd_sel   = 2'd2;
    @(negedge clk);
    chk("held_cmd_ready", 32'(sif.cmd_ready), 32'd0);
    chk("held_busy", 32'(sif.busy), 32'd1);
    chk("held_idx", 32'(sif.freq_idx), 32'd1);
    issue(1'b0, 2'd2, 16'h0777, 16'd0);
    @(negedge clk);
    count_low(lo);
    chk("dw0_low_cycles", 32'(lo), 32'd65);
    count_high(hi);
    chk("dw0_high_cycles", 32'(hi), 32'd1);

    // 6: asynchronous reset mid-DWELL in scan mode
    issue(1'b1, 2'd1, 16'h0ABC, 16'd20);
    @(negedge clk);
    count_low(lo);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_phaseinc", sif.PhaseInc, 32'd85899346);
    chk("arst_freqmod", sif.FreqMod, 32'd0);
    chk("arst_phasemod", 32'(sif.PhaseMod), 32'd0);
    chk("arst_idx", 32'(sif.freq_idx), 32'd1);
    chk("arst_acq", 32'(sif.acq_en), 32'd0);
    chk("arst_busy", 32'(sif.busy), 32'd0);
    chk("arst_cmd_ready", 32'(sif.cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(sif.busy), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
